// File: rtl/vote_pkg.sv
// vote_pkg: shared FSM state and RGB encodings for vote_session_ctrl.
package vote_pkg;
    typedef logic [1:0] vote_state_t;
    localparam vote_state_t S_IDLE    = 2'd0;
    localparam vote_state_t S_COLLECT = 2'd1;
    localparam vote_state_t S_DECIDE  = 2'd2;
    localparam vote_state_t S_SHOW    = 2'd3;
    // rgb is {red, green, blue}
    localparam logic [2:0] RGB_OFF   = 3'b000;
    localparam logic [2:0] RGB_BLUE  = 3'b001;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_RED   = 3'b100;
endpackage

// File: rtl/vote_session_ctrl_maj3.sv
// maj3: combinational 2-of-3 majority.
module maj3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: three-voter session controller (collect, decide, show).
// Optional VOTE_TALLY_EN adds saturating pass/fail session counters.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int SHOW_CYCLES   = 500
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       vote_a,
    input  logic       vote_b,
    input  logic       vote_c,
    input  logic       cast_a,
    input  logic       cast_b,
    input  logic       cast_c,
    output logic       busy,
    output logic       done,
    output logic       result,
    output logic       result_valid,
    output logic       timeout,
    output logic [2:0] rgb
`ifdef VOTE_TALLY_EN
    ,
    output logic [7:0] pass_cnt,
    output logic [7:0] fail_cnt
`endif
);
    localparam int WW = $clog2(WINDOW_CYCLES + 1);
    localparam int SW = $clog2(SHOW_CYCLES + 1);

    vote_state_t   state;
    logic [WW-1:0] wcnt;
    logic [SW-1:0] scnt;
    logic [2:0]    cast_f, votes, cast_in, vote_in, new_cast, cast_nx, votes_nx;
    logic          maj;

    assign cast_in  = {cast_a, cast_b, cast_c};
    assign vote_in  = {vote_a, vote_b, vote_c};
    assign new_cast = cast_in & ~cast_f;
    assign cast_nx  = cast_f | cast_in;
    assign votes_nx = votes | (vote_in & new_cast);

    maj3 u_maj3 (.a(votes[2]), .b(votes[1]), .c(votes[0]), .y(maj));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            wcnt         <= '0;
            scnt         <= '0;
            cast_f       <= '0;
            votes        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            rgb          <= RGB_OFF;
`ifdef VOTE_TALLY_EN
            pass_cnt     <= '0;
            fail_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_COLLECT;
                    busy    <= 1'b1;
                    cast_f  <= '0;
                    votes   <= '0;
                    timeout <= 1'b0;
                    wcnt    <= WW'(WINDOW_CYCLES);
                    rgb     <= RGB_BLUE;
                end
                S_COLLECT: if (&cast_f) begin
                    state <= S_DECIDE;
                end else begin
                    cast_f <= cast_nx;
                    votes  <= votes_nx;
                    if (wcnt != '0) wcnt <= wcnt - WW'(1);
                    // a cast completing the set in the last window cycle wins over expiry
                    if (wcnt == WW'(1) && !(&cast_nx)) state <= S_DECIDE;
                end
                S_DECIDE: begin
                    state        <= S_SHOW;
                    result       <= maj;
                    done         <= 1'b1;
                    result_valid <= 1'b1;
                    timeout      <= ~&cast_f;
                    rgb          <= maj ? RGB_GREEN : RGB_RED;
                    scnt         <= SW'(SHOW_CYCLES);
`ifdef VOTE_TALLY_EN
                    if (maj && pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
                    if (!maj && fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
`endif
                end
                default: begin
                    done <= 1'b0;
                    scnt <= scnt - SW'(1);
                    if (scnt == SW'(1)) begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                        rgb          <= RGB_OFF;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: directed checks of vote_session_ctrl, WINDOW_CYCLES=8, SHOW_CYCLES=4.
// Status vector o = {busy, done, result, result_valid, timeout, rgb[2:0]}.
module tb_vote_session_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic vote_a = 1'b0, vote_b = 1'b0, vote_c = 1'b0;
    logic cast_a = 1'b0, cast_b = 1'b0, cast_c = 1'b0;
    logic busy, done, result, result_valid, timeout;
    logic [2:0] rgb;
    logic [7:0] o;
    int checks = 0;
    int errors = 0;
`ifdef VOTE_TALLY_EN
    logic [7:0] pass_cnt, fail_cnt;
`endif

    vote_session_ctrl #(.WINDOW_CYCLES(8), .SHOW_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .vote_a(vote_a), .vote_b(vote_b), .vote_c(vote_c),
        .cast_a(cast_a), .cast_b(cast_b), .cast_c(cast_c),
        .busy(busy), .done(done), .result(result), .result_valid(result_valid),
        .timeout(timeout), .rgb(rgb)
`ifdef VOTE_TALLY_EN
        , .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign o = {busy, done, result, result_valid, timeout, rgb};

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cast(input logic [2:0] c, input logic [2:0] v);
        {cast_a, cast_b, cast_c} = c;
        {vote_a, vote_b, vote_c} = v;
        tick();
        {cast_a, cast_b, cast_c} = 3'b000;
        {vote_a, vote_b, vote_c} = 3'b000;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        checks++; if (o !== 8'b0) begin errors++; $display("FAIL reset: got %b exp %b", o, 8'b0); end
        resetn = 1'b1;
        tick();
        checks++; if (o !== 8'b0) begin errors++; $display("FAIL reset_idle: got %b exp %b", o, 8'b0); end
    endtask

    task automatic test_pass_session();
        go();
        checks++; if (o !== 8'b1_0_0_0_0_001) begin errors++; $display("FAIL p_start: got %b exp %b", o, 8'b1_0_0_0_0_001); end
        cast(3'b100, 3'b100);
        cast(3'b010, 3'b010);
        cast(3'b001, 3'b000);
        checks++; if (o !== 8'b1_0_0_0_0_001) begin errors++; $display("FAIL p_E: got %b exp %b", o, 8'b1_0_0_0_0_001); end
        tick();
        checks++; if (o !== 8'b1_0_0_0_0_001) begin errors++; $display("FAIL p_E1: got %b exp %b", o, 8'b1_0_0_0_0_001); end
        tick();
        checks++; if (o !== 8'b1_1_1_1_0_010) begin errors++; $display("FAIL p_E2: got %b exp %b", o, 8'b1_1_1_1_0_010); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o !== 8'b1_0_1_1_0_010) begin errors++; $display("FAIL p_show%0d: got %b exp %b", i, o, 8'b1_0_1_1_0_010); end
        end
        tick();
        checks++; if (o !== 8'b0_0_1_0_0_000) begin errors++; $display("FAIL p_idle: got %b exp %b", o, 8'b0_0_1_0_0_000); end
    endtask

    task automatic test_timeout();
        go();
        cast(3'b100, 3'b100);
        tick(7);
        checks++; if (o !== 8'b1_0_1_0_0_001) begin errors++; $display("FAIL t_window: got %b exp %b", o, 8'b1_0_1_0_0_001); end
        tick();
        checks++; if (o !== 8'b1_1_0_1_1_100) begin errors++; $display("FAIL t_done: got %b exp %b", o, 8'b1_1_0_1_1_100); end
        tick(3);
        checks++; if (o !== 8'b1_0_0_1_1_100) begin errors++; $display("FAIL t_show: got %b exp %b", o, 8'b1_0_0_1_1_100); end
        tick();
        checks++; if (o !== 8'b0_0_0_0_1_000) begin errors++; $display("FAIL t_idle: got %b exp %b", o, 8'b0_0_0_0_1_000); end
    endtask

    task automatic test_first_cast_and_simultaneous();
        go();
        checks++; if (o !== 8'b1_0_0_0_0_001) begin errors++; $display("FAIL d_start: got %b exp %b", o, 8'b1_0_0_0_0_001); end
        cast(3'b100, 3'b000);
        cast(3'b100, 3'b100);
        cast(3'b010, 3'b010);
        cast(3'b001, 3'b000);
        tick(2);
        checks++; if (o !== 8'b1_1_0_1_0_100) begin errors++; $display("FAIL d_keep_first: got %b exp %b", o, 8'b1_1_0_1_0_100); end
        tick(4);
        checks++; if (o !== 8'b0) begin errors++; $display("FAIL d_idle: got %b exp %b", o, 8'b0); end
        go();
        cast(3'b111, 3'b111);
        checks++; if (o !== 8'b1_0_0_0_0_001) begin errors++; $display("FAIL s_E: got %b exp %b", o, 8'b1_0_0_0_0_001); end
        tick();
        checks++; if (o !== 8'b1_0_0_0_0_001) begin errors++; $display("FAIL s_E1: got %b exp %b", o, 8'b1_0_0_0_0_001); end
        tick();
        checks++; if (o !== 8'b1_1_1_1_0_010) begin errors++; $display("FAIL s_E2: got %b exp %b", o, 8'b1_1_1_1_0_010); end
        tick(4);
        checks++; if (o !== 8'b0_0_1_0_0_000) begin errors++; $display("FAIL s_idle: got %b exp %b", o, 8'b0_0_1_0_0_000); end
    endtask

    task automatic test_last_window_cast();
        go();
        cast(3'b100, 3'b100);
        cast(3'b010, 3'b010);
        tick(5);
        cast(3'b001, 3'b000);
        checks++; if (o !== 8'b1_0_1_0_0_001) begin errors++; $display("FAIL w_E: got %b exp %b", o, 8'b1_0_1_0_0_001); end
        tick();
        checks++; if (o !== 8'b1_0_1_0_0_001) begin errors++; $display("FAIL w_E1: got %b exp %b", o, 8'b1_0_1_0_0_001); end
        tick();
        checks++; if (o !== 8'b1_1_1_1_0_010) begin errors++; $display("FAIL w_E2: got %b exp %b", o, 8'b1_1_1_1_0_010); end
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o !== 8'b1_0_1_1_0_010) begin errors++; $display("FAIL w_start_show%0d: got %b exp %b", i, o, 8'b1_0_1_1_0_010); end
        end
        start = 1'b0;
        tick();
        checks++; if (o !== 8'b0_0_1_0_0_000) begin errors++; $display("FAIL w_idle: got %b exp %b", o, 8'b0_0_1_0_0_000); end
        tick();
        checks++; if (o !== 8'b0_0_1_0_0_000) begin errors++; $display("FAIL w_no_restart: got %b exp %b", o, 8'b0_0_1_0_0_000); end
    endtask

    task automatic test_async_reset();
        go();
        cast(3'b100, 3'b100);
        checks++; if (o !== 8'b1_0_1_0_0_001) begin errors++; $display("FAIL r_collect: got %b exp %b", o, 8'b1_0_1_0_0_001); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (o !== 8'b0) begin errors++; $display("FAIL r_mid_collect: got %b exp %b", o, 8'b0); end
        resetn = 1'b1;
        tick();
        checks++; if (o !== 8'b0) begin errors++; $display("FAIL r_collect_idle: got %b exp %b", o, 8'b0); end
        go();
        cast(3'b111, 3'b111);
        tick(3);
        checks++; if (o !== 8'b1_0_1_1_0_010) begin errors++; $display("FAIL r_show: got %b exp %b", o, 8'b1_0_1_1_0_010); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (o !== 8'b0) begin errors++; $display("FAIL r_mid_show: got %b exp %b", o, 8'b0); end
        resetn = 1'b1;
        tick();
        checks++; if (o !== 8'b0) begin errors++; $display("FAIL r_show_idle: got %b exp %b", o, 8'b0); end
        go();
        checks++; if (o !== 8'b1_0_0_0_0_001) begin errors++; $display("FAIL r_resume: got %b exp %b", o, 8'b1_0_0_0_0_001); end
        cast(3'b111, 3'b011);
        tick(2);
        checks++; if (o !== 8'b1_1_1_1_0_010) begin errors++; $display("FAIL r_resume_done: got %b exp %b", o, 8'b1_1_1_1_0_010); end
        tick(4);
    endtask

`ifdef VOTE_TALLY_EN
    task automatic test_tally();
        resetn = 1'b0;
        #2 resetn = 1'b1;
        tick();
        checks++; if ({pass_cnt, fail_cnt} !== 16'h0) begin errors++; $display("FAIL tally_reset: got %h exp %h", {pass_cnt, fail_cnt}, 16'h0); end
        go();
        cast(3'b111, 3'b000);
        tick(6);
        checks++; if ({pass_cnt, fail_cnt} !== 16'h0001) begin errors++; $display("FAIL tally_fail: got %h exp %h", {pass_cnt, fail_cnt}, 16'h0001); end
        for (int i = 0; i < 256; i++) begin
            go();
            cast(3'b111, 3'b111);
            tick(6);
        end
        checks++; if ({pass_cnt, fail_cnt} !== 16'hFF01) begin errors++; $display("FAIL tally_sat: got %h exp %h", {pass_cnt, fail_cnt}, 16'hFF01); end
    endtask
`endif

    initial begin
        test_reset();
        test_pass_session();
        test_timeout();
        test_first_cast_and_simultaneous();
        test_last_window_cast();
        test_async_reset();
`ifdef VOTE_TALLY_EN
        test_tally();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
